// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: memory opcodes,
// FSM state encoding and small opcode classification helpers.
// The alignment check is used only when MEM_ALIGN_EXC_EN is defined.
package mem_stage_ctrl_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2b;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_mem(input logic [5:0] op);
      return is_load(op) || is_store(op);
   endfunction

   // Halfwords need an even address, words need a multiple of four.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
      logic half_op;
      logic word_op;
      half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word_op = (op == OP_LW) || (op == OP_SW);
      return (half_op && a[0]) || (word_op && (a != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge port. The controller is the master;
// the memory (or a testbench model of it) is the slave.
interface mem_stage_ctrl_if #(
   parameter int ADDR_W = 32
) ();

   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              dmem_ack;
   logic [31:0]       dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_be,
      output dmem_wdata,
      input  dmem_ack,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_be,
      input  dmem_wdata,
      output dmem_ack,
      output dmem_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane-replicated
// store data, plus extraction and sign/zero extension of load data.
// Misaligned low address bits are simply masked off here.
module mem_lane_align
   import mem_stage_ctrl_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  a,
   input  logic [31:0] val_a,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the read word.
   always_comb begin
      byte_sel = rdata[7:0];
      case (a)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = a[1] ? rdata[31:16] : rdata[15:0];
   end

   // Lane enables, store replication and load extension per opcode.
   always_comb begin
      be       = 4'b0000;
      wdata    = val_a;
      load_val = rdata;
      case (op)
         OP_SB: begin
            be    = 4'b0001 << a;
            wdata = {4{val_a[7:0]}};
         end
         OP_SH: begin
            be    = 4'b0011 << {a[1], 1'b0};
            wdata = {2{val_a[15:0]}};
         end
         OP_SW: begin
            be = 4'b1111;
         end
         OP_LB: begin
            be       = 4'b0001 << a;
            load_val = {{24{byte_sel[7]}}, byte_sel};
         end
         OP_LBU: begin
            be       = 4'b0001 << a;
            load_val = {24'h000000, byte_sel};
         end
         OP_LH: begin
            be       = 4'b0011 << {a[1], 1'b0};
            load_val = {{16{half_sel[15]}}, half_sel};
         end
         OP_LHU: begin
            be       = 4'b0011 << {a[1], 1'b0};
            load_val = {16'h0000, half_sel};
         end
         OP_LW: begin
            be = 4'b1111;
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns load/store ops from the M register into
// a req/ack data-memory transaction, stalls the pipeline until it ends and
// registers the extended load result for writeback.
// Optional feature macro: MEM_ALIGN_EXC_EN (misaligned ops raise m_exc
// instead of being issued).
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  M_op,
   input  logic [31:0] M_valE,
   input  logic [31:0] M_valA,
   input  logic [4:0]  M_dstE,
   input  logic [4:0]  M_dstM,
   output logic        m_stall,
   output logic [31:0] m_valM,
   output logic [4:0]  m_dstE,
   output logic [4:0]  m_dstM,
   output logic        m_exc,
   mem_stage_ctrl_if.master dmem
);

   mem_state_e  state;
   mem_state_e  next_state;
   logic        req;
   logic        capture;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load;
   logic        mem_op;
   logic        misaligned;

   assign mem_op     = is_mem(M_op);
`ifdef MEM_ALIGN_EXC_EN
   assign misaligned = is_misaligned(M_op, M_valE[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   mem_lane_align u_lane (
      .op       (M_op),
      .a        (M_valE[1:0]),
      .val_a    (M_valA),
      .rdata    (dmem.dmem_rdata),
      .be       (lane_be),
      .wdata    (lane_wdata),
      .load_val (lane_load)
   );

   assign m_dstE           = M_dstE;
   assign m_dstM           = M_dstM;
   assign dmem.dmem_req    = req;
   assign dmem.dmem_we     = is_store(M_op);
   assign dmem.dmem_addr   = {M_valE[ADDR_W-1:2], 2'b00};
   assign dmem.dmem_be     = lane_be;
   assign dmem.dmem_wdata  = lane_wdata;

   // State register; reset abandons any outstanding request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MEM_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state, stall and request decode for the access handshake.
   always_comb begin
      next_state = state;
      m_stall    = 1'b0;
      req        = 1'b0;
      capture    = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (mem_op) begin
               m_stall    = 1'b1;
               next_state = misaligned ? MEM_DONE : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            req     = 1'b1;
            m_stall = 1'b1;
            if (dmem.dmem_ack) begin
               capture    = is_load(M_op);
               next_state = MEM_DONE;
            end
         end
         MEM_DONE: begin
            next_state = MEM_IDLE;
         end
         default: begin
            next_state = MEM_IDLE;
         end
      endcase
   end

   // Load result register; holds its value across stores and non-memory ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valM <= 32'h0;
      end else if (capture) begin
         m_valM <= lane_load;
      end
   end

`ifdef MEM_ALIGN_EXC_EN
   // Flag is raised only for the DONE cycle that follows a rejected op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_exc <= 1'b0;
      end else begin
         m_exc <= (state == MEM_IDLE) && mem_op && misaligned;
      end
   end
`else
   assign m_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl with a scripted memory responder.
module tb_mem_stage_ctrl;

   localparam logic [5:0] T_ADD = 6'h00;
   localparam logic [5:0] T_LB  = 6'h20;
   localparam logic [5:0] T_LH  = 6'h21;
   localparam logic [5:0] T_LW  = 6'h23;
   localparam logic [5:0] T_LBU = 6'h24;
   localparam logic [5:0] T_LHU = 6'h25;
   localparam logic [5:0] T_SB  = 6'h28;
   localparam logic [5:0] T_SH  = 6'h29;
   localparam logic [5:0] T_SW  = 6'h2b;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  M_op = 6'h00;
   logic [31:0] M_valE = 32'h0;
   logic [31:0] M_valA = 32'h0;
   logic [4:0]  M_dstE = 5'd0;
   logic [4:0]  M_dstM = 5'd0;
   logic        m_stall;
   logic [31:0] m_valM;
   logic [4:0]  m_dstE;
   logic [4:0]  m_dstM;
   logic        m_exc;

   int assertCount = 0;
   int failCount = 0;

   int          stallCycles;
   int          reqCycles;
   logic        accessDone;
   logic [31:0] busAddr;
   logic [3:0]  busBe;
   logic        busWe;
   logic [31:0] busWdata;
   logic [31:0] doneValM;
   logic        doneExc;
   logic        idleStall;
   logic        idleExc;

   mem_stage_ctrl_if #(.ADDR_W(32)) dmem_bus ();

   mem_stage_ctrl #(.ADDR_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .M_op    (M_op),
      .M_valE  (M_valE),
      .M_valA  (M_valA),
      .M_dstE  (M_dstE),
      .M_dstM  (M_dstM),
      .m_stall (m_stall),
      .m_valM  (m_valM),
      .m_dstE  (m_dstE),
      .m_dstM  (m_dstM),
      .m_exc   (m_exc),
      .dmem    (dmem_bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] valE,
                                input logic [31:0] valA);
      M_op   = op;
      M_valE = valE;
      M_valA = valA;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one access from IDLE; acks after 'waits' request cycles, records
   // bus fields, stall/request counts, and the state of the DONE and IDLE cycles.
   task automatic runAccess(input logic [5:0] op, input logic [31:0] valE,
                            input logic [31:0] valA, input logic [31:0] rdata,
                            input int waits);
      stallCycles = 0;
      reqCycles   = 0;
      accessDone  = 1'b0;
      busAddr = 32'hx; busBe = 4'hx; busWe = 1'bx; busWdata = 32'hx;
      applyStimulus(op, valE, valA);
      for (int cyc = 0; cyc < 20; cyc++) begin
         dmem_bus.dmem_rdata = rdata;
         dmem_bus.dmem_ack   = dmem_bus.dmem_req && (reqCycles == waits);
         #1;
         if (m_stall) stallCycles++;
         if (dmem_bus.dmem_req) begin
            reqCycles++;
            busAddr  = dmem_bus.dmem_addr;
            busBe    = dmem_bus.dmem_be;
            busWe    = dmem_bus.dmem_we;
            busWdata = dmem_bus.dmem_wdata;
         end
         if (!m_stall) begin
            accessDone = 1'b1;
            break;
         end
         stepCycle();
      end
      dmem_bus.dmem_ack = 1'b0;
      doneValM = m_valM;
      doneExc  = m_exc;
      applyStimulus(T_ADD, 32'h0, 32'h0);
      stepCycle();
      idleStall = m_stall;
      idleExc   = m_exc;
      checkOutput("access_completes", {31'b0, accessDone}, 32'd1);
   endtask

   initial begin
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 32'h0;
      #1;
      checkOutput("reset_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
      checkOutput("reset_valM", m_valM, 32'h0);
      checkOutput("reset_exc", {31'b0, m_exc}, 32'd0);
      checkOutput("reset_stall", {31'b0, m_stall}, 32'd0);
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      stepCycle();

      $display("[TB] zero-wait SW");
      runAccess(T_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      checkOutput("sw_stall", stallCycles, 32'd2);
      checkOutput("sw_req", reqCycles, 32'd1);
      checkOutput("sw_we", {31'b0, busWe}, 32'd1);
      checkOutput("sw_be", {28'b0, busBe}, 32'hF);
      checkOutput("sw_addr", busAddr, 32'h100);
      checkOutput("sw_wdata", busWdata, 32'hDEADBEEF);
      checkOutput("sw_valM", doneValM, 32'h0);
      checkOutput("sw_idle", {31'b0, idleStall}, 32'd0);

      $display("[TB] LB with two wait states");
      runAccess(T_LB, 32'h203, 32'h0, 32'h80FFFFFF, 2);
      checkOutput("lb_stall", stallCycles, 32'd4);
      checkOutput("lb_req", reqCycles, 32'd3);
      checkOutput("lb_we", {31'b0, busWe}, 32'd0);
      checkOutput("lb_addr", busAddr, 32'h200);
      checkOutput("lb_valM", doneValM, 32'hFFFFFF80);

      runAccess(T_LBU, 32'h203, 32'h0, 32'h80FFFFFF, 2);
      checkOutput("lbu_stall", stallCycles, 32'd4);
      checkOutput("lbu_valM", doneValM, 32'h00000080);

      $display("[TB] halfword and byte stores");
      runAccess(T_SH, 32'h102, 32'h00001234, 32'hFFFFFFFF, 0);
      checkOutput("sh_be", {28'b0, busBe}, 32'hC);
      checkOutput("sh_wdata", busWdata, 32'h12341234);
      checkOutput("sh_addr", busAddr, 32'h100);
      checkOutput("sh_valM_held", doneValM, 32'h00000080);

      runAccess(T_SB, 32'h101, 32'h000000AB, 32'h0, 1);
      checkOutput("sb_be", {28'b0, busBe}, 32'h2);
      checkOutput("sb_wdata", busWdata, 32'hABABABAB);
      checkOutput("sb_stall", stallCycles, 32'd3);

      $display("[TB] halfword and word loads");
      runAccess(T_LH, 32'h202, 32'h0, 32'h80017FFF, 0);
      checkOutput("lh_valM", doneValM, 32'hFFFF8001);
      runAccess(T_LHU, 32'h202, 32'h0, 32'h80017FFF, 0);
      checkOutput("lhu_valM", doneValM, 32'h00008001);
      runAccess(T_LW, 32'h200, 32'h0, 32'h12345678, 1);
      checkOutput("lw_valM", doneValM, 32'h12345678);
      checkOutput("lw_be", {28'b0, busBe}, 32'hF);
      runAccess(T_LB, 32'h201, 32'h0, 32'h00007F00, 0);
      checkOutput("lb_pos_valM", doneValM, 32'h0000007F);

      $display("[TB] non-memory stream with stray ack");
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 1) ? 6'h0c : ((i == 2) ? 6'h22 : T_ADD), 32'h203 + i, 32'h55);
         M_dstE = 5'(i + 3);
         M_dstM = 5'(i + 17);
         dmem_bus.dmem_ack   = (i >= 2);
         dmem_bus.dmem_rdata = 32'hFFFFFFFF;
         #1;
         checkOutput("nop_stall", {31'b0, m_stall}, 32'd0);
         checkOutput("nop_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
         checkOutput("nop_dstE", {27'b0, m_dstE}, i + 3);
         checkOutput("nop_dstM", {27'b0, m_dstM}, i + 17);
         stepCycle();
         checkOutput("nop_valM", m_valM, 32'h0000007F);
      end
      dmem_bus.dmem_ack = 1'b0;

      $display("[TB] reset during WAIT");
      applyStimulus(T_LW, 32'h300, 32'h0);
      stepCycle();
      checkOutput("rst_wait_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
      rst_n = 1'b0;
      applyStimulus(T_ADD, 32'h0, 32'h0);
      #1;
      checkOutput("rst_req_drop", {31'b0, dmem_bus.dmem_req}, 32'd0);
      checkOutput("rst_valM", m_valM, 32'h0);
      stepCycle();
      rst_n = 1'b1;
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = 32'hA5A5A5A5;
      stepCycle();
      dmem_bus.dmem_ack = 1'b0;
      checkOutput("rst_late_ack_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
      checkOutput("rst_late_ack_stall", {31'b0, m_stall}, 32'd0);
      checkOutput("rst_late_ack_valM", m_valM, 32'h0);

      $display("[TB] misaligned LW");
      runAccess(T_LW, 32'h102, 32'h0, 32'hCAFEF00D, 0);
`ifdef MEM_ALIGN_EXC_EN
      checkOutput("mis_req", reqCycles, 32'd0);
      checkOutput("mis_stall", stallCycles, 32'd1);
      checkOutput("mis_exc", {31'b0, doneExc}, 32'd1);
      checkOutput("mis_valM", doneValM, 32'h0);
`else
      checkOutput("mis_req", reqCycles, 32'd1);
      checkOutput("mis_addr", busAddr, 32'h100);
      checkOutput("mis_exc", {31'b0, doneExc}, 32'd0);
      checkOutput("mis_valM", doneValM, 32'hCAFEF00D);
`endif
      checkOutput("mis_exc_clear", {31'b0, idleExc}, 32'd0);
      checkOutput("mis_idle", {31'b0, idleStall}, 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
